// File: rtl/line_cmd_sequencer.sv
// rtl/line_cmd_sequencer.sv - line command FIFO and launcher feeding the line drawer
// Buffers endpoint commands, runs one drawer pass per command and forwards its pixels.
module line_cmd_sequencer #(
  parameter int DEPTH   = 4,
  parameter int PIX_LAT = 2,
  parameter int TIMEOUT = 2047
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [10:0] cmd_x0_i,
  input  logic [10:0] cmd_y0_i,
  input  logic [10:0] cmd_x1_i,
  input  logic [10:0] cmd_y1_i,
  output logic        drw_reset_o,
  output logic [10:0] drw_x0_o,
  output logic [10:0] drw_y0_o,
  output logic [10:0] drw_x1_o,
  output logic [10:0] drw_y1_o,
  input  logic [10:0] drw_x_i,
  input  logic [10:0] drw_y_i,
  input  logic        drw_done_i,
  output logic        pix_we_o,
  output logic [10:0] pix_x_o,
  output logic [10:0] pix_y_o,
  output logic        busy_o,
  output logic [15:0] lines_done_o,
  output logic        timeout_err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAT_C  = CW'(PIX_LAT);
  localparam logic [CW-1:0] TO_C   = CW'(TIMEOUT);
  localparam logic [AW:0]   FULL_C = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  logic [43:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          full, empty, push, pop;
  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          cnt_qual;
  logic [43:0]   head;

  assign full        = (count_q == FULL_C);
  assign empty       = (count_q == '0);
  assign cmd_ready_o = !full && !reset;
  assign push        = cmd_valid_i && cmd_ready_o;
  assign pop         = (state_q == IDLE) && !empty;
  assign busy_o      = (state_q != IDLE) || !empty;
  assign head        = mem_q[rd_ptr_q];
  // Drawer outputs are stale for the first PIX_LAT cycles after its reset drops.
  assign cnt_qual    = (cnt_q >= LAT_C);

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + (AW+1)'(1);
    else if (!push && pop) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_x0_i, cmd_y0_i, cmd_x1_i, cmd_y1_i};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      drw_reset_o   <= 1'b1;
      drw_x0_o      <= '0;
      drw_y0_o      <= '0;
      drw_x1_o      <= '0;
      drw_y1_o      <= '0;
      pix_we_o      <= 1'b0;
      pix_x_o       <= '0;
      pix_y_o       <= '0;
      lines_done_o  <= '0;
      timeout_err_o <= 1'b0;
      cnt_q         <= '0;
    end else begin
      pix_we_o <= 1'b0;
      case (state_q)
        IDLE: begin
          drw_reset_o <= 1'b1;
          if (!empty) begin
            {drw_x0_o, drw_y0_o, drw_x1_o, drw_y1_o} <= head;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          drw_reset_o <= 1'b0;
          cnt_q       <= '0;
          state_q     <= RUN;
        end
        RUN: begin
          if (cnt_q != TO_C) cnt_q <= cnt_q + CW'(1);
          if (drw_done_i && cnt_qual) begin
            pix_we_o     <= 1'b1;
            pix_x_o      <= drw_x_i;
            pix_y_o      <= drw_y_i;
            lines_done_o <= lines_done_o + 16'd1;
            drw_reset_o  <= 1'b1;
            state_q      <= IDLE;
          end else if (cnt_q == TO_C) begin
            timeout_err_o <= 1'b1;
            drw_reset_o   <= 1'b1;
            state_q       <= IDLE;
          end else if (cnt_qual) begin
            pix_we_o <= 1'b1;
            pix_x_o  <= drw_x_i;
            pix_y_o  <= drw_y_i;
          end
        end
        default: begin
          drw_reset_o <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_line_cmd_sequencer.sv
// tb/tb_line_cmd_sequencer.sv - self-checking bench for line_cmd_sequencer
// Contains a behavioural line drawer and an expected-pixel scoreboard.
module tb_line_cmd_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid_i, cmd_ready_o;
  logic [10:0] cmd_x0_i, cmd_y0_i, cmd_x1_i, cmd_y1_i;
  logic        drw_reset_o;
  logic [10:0] drw_x0_o, drw_y0_o, drw_x1_o, drw_y1_o;
  logic [10:0] drw_x_i, drw_y_i;
  logic        drw_done_i;
  logic        pix_we_o;
  logic [10:0] pix_x_o, pix_y_o;
  logic        busy_o;
  logic [15:0] lines_done_o;
  logic        timeout_err_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_lines = 0;
  int last_wr = 0;
  int wr_count = 0;
  int wr_cyc[$];
  bit stub_mode = 0;

  typedef struct {
    logic [21:0] xy;
    bit          first;
    bit          last;
  } px_t;
  px_t exp_q[$];

  int dk = 0;
  int ex0 = 0, ey0 = 0, ex1 = 0, ey1 = 0;
  logic [21:0] pt;

  line_cmd_sequencer #(.DEPTH(4), .PIX_LAT(2), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_x0_i(cmd_x0_i), .cmd_y0_i(cmd_y0_i), .cmd_x1_i(cmd_x1_i), .cmd_y1_i(cmd_y1_i),
    .drw_reset_o(drw_reset_o),
    .drw_x0_o(drw_x0_o), .drw_y0_o(drw_y0_o), .drw_x1_o(drw_x1_o), .drw_y1_o(drw_y1_o),
    .drw_x_i(drw_x_i), .drw_y_i(drw_y_i), .drw_done_i(drw_done_i),
    .pix_we_o(pix_we_o), .pix_x_o(pix_x_o), .pix_y_o(pix_y_o),
    .busy_o(busy_o), .lines_done_o(lines_done_o), .timeout_err_o(timeout_err_o)
  );

  always #5 clk = ~clk;

  function automatic int bres_len(input int x0, input int y0, input int x1, input int y1);
    int dx, dy;
    dx = (x1 > x0) ? x1 - x0 : x0 - x1;
    dy = (y1 > y0) ? y1 - y0 : y0 - y1;
    return ((dx > dy) ? dx : dy) + 1;
  endfunction

  function automatic logic [21:0] bres_pt(input int x0, input int y0, input int x1, input int y1,
                                          input int p);
    int dx, dy, sx, sy, err, e2, x, y;
    dx = (x1 > x0) ? x1 - x0 : x0 - x1;
    dy = -((y1 > y0) ? y1 - y0 : y0 - y1);
    sx = (x0 < x1) ? 1 : -1;
    sy = (y0 < y1) ? 1 : -1;
    err = dx + dy;
    x = x0;
    y = y0;
    for (int i = 0; i < p; i++) begin
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
    return {x[10:0], y[10:0]};
  endfunction

  // Drawer: pixel valid PIX_LAT cycles after reset release, done flagged spuriously while stale.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (drw_reset_o) begin
      dk  <= 0;
      ex0 <= int'(drw_x0_o);
      ey0 <= int'(drw_y0_o);
      ex1 <= int'(drw_x1_o);
      ey1 <= int'(drw_y1_o);
    end else if (dk < 10000) begin
      dk <= dk + 1;
    end
  end

  always_comb begin
    drw_x_i    = 11'h555;
    drw_y_i    = 11'h2aa;
    drw_done_i = 1'b0;
    pt         = '0;
    if (stub_mode) begin
      if (dk >= 2) begin
        drw_x_i = 11'(dk);
        drw_y_i = 11'(100 + dk);
      end
    end else if (dk < 2) begin
      drw_done_i = 1'b1;
    end else begin
      pt         = bres_pt(ex0, ey0, ex1, ey1, dk - 2);
      drw_x_i    = pt[21:11];
      drw_y_i    = pt[10:0];
      drw_done_i = ((dk - 2) >= bres_len(ex0, ey0, ex1, ey1) - 1);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && pix_we_o) begin
      px_t e;
      wr_count++;
      wr_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("unexpected_write", {10'd0, pix_x_o, pix_y_o}, 32'hffff_ffff);
      end else begin
        e = exp_q.pop_front();
        check("pix_xy", {10'd0, pix_x_o, pix_y_o}, {10'd0, e.xy});
        if (!e.first) check("pix_consecutive", cyc - last_wr, 1);
        if (e.last) exp_lines++;
      end
      last_wr = cyc;
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int x0, input int y0, input int x1, input int y1);
    bit ok;
    int n;
    px_t e;
    ok = 0;
    cmd_x0_i = 11'(x0);
    cmd_y0_i = 11'(y0);
    cmd_x1_i = 11'(x1);
    cmd_y1_i = 11'(y1);
    cmd_valid_i = 1'b1;
    for (int t = 0; t < 200; t++) begin
      if (cmd_ready_o) begin ok = 1; break; end
      tick(1);
    end
    check("push_accept", {31'd0, ok}, 1);
    if (ok) begin
      if (stub_mode) begin
        for (int k = 2; k < 16; k++) begin
          e.xy = {11'(k), 11'(100 + k)};
          e.first = (k == 2);
          e.last = 0;
          exp_q.push_back(e);
        end
      end else begin
        n = bres_len(x0, y0, x1, y1);
        for (int p = 0; p < n; p++) begin
          e.xy = bres_pt(x0, y0, x1, y1, p);
          e.first = (p == 0);
          e.last = (p == n - 1);
          exp_q.push_back(e);
        end
      end
      tick(1);
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int t = 0; t < 1000; t++) begin
      if (!busy_o) begin ok = 1; break; end
      tick(1);
    end
    if (!ok) check("wait_idle_bound", 0, 1);
    tick(2);
  endtask

  task automatic end_of_test(input string tag);
    check({tag, "_queue_left"}, exp_q.size(), 0);
    check({tag, "_lines_done"}, {16'd0, lines_done_o}, exp_lines);
    check({tag, "_busy"}, {31'd0, busy_o}, 0);
  endtask

  initial begin
    bit ok;
    int rx0, ry0, rx1, ry1;
    reset = 1'b1;
    cmd_valid_i = 1'b0;
    cmd_x0_i = '0; cmd_y0_i = '0; cmd_x1_i = '0; cmd_y1_i = '0;
    tick(3);
    check("rst_drw_reset", {31'd0, drw_reset_o}, 1);
    check("rst_drw_ep", {drw_x0_o, drw_y0_o, drw_x1_o[9:0]}, 0);
    check("rst_pix", {9'd0, pix_we_o, pix_x_o, pix_y_o}, 0);
    check("rst_lines", {16'd0, lines_done_o}, 0);
    check("rst_timeout", {31'd0, timeout_err_o}, 0);
    check("rst_busy", {31'd0, busy_o}, 0);
    check("rst_ready", {31'd0, cmd_ready_o}, 0);
    reset = 1'b0;
    #1;
    check("ready_after_rst", {31'd0, cmd_ready_o}, 1);

    // horizontal line
    push(3, 2, 7, 2);
    cmd_valid_i = 1'b0;
    wait_idle();
    end_of_test("horiz");
    check("horiz_count", exp_lines, 1);

    // vertical and diagonal
    push(3, 2, 3, 6);
    cmd_valid_i = 1'b0;
    wait_idle();
    push(1, 1, 5, 5);
    cmd_valid_i = 1'b0;
    wait_idle();
    end_of_test("vert_diag");

    // back-to-back with fixed launch gap
    wr_cyc.delete();
    push(1, 1, 12, 5);
    push(0, 0, 0, 0);
    cmd_valid_i = 1'b0;
    wait_idle();
    end_of_test("b2b");
    check("b2b_writes", wr_cyc.size(), 13);
    if (wr_cyc.size() == 13) check("b2b_gap", wr_cyc[12] - wr_cyc[11], 5);

    // fill the FIFO while a long line runs
    push(0, 0, 11, 3);
    cmd_valid_i = 1'b0;
    tick(1);
    push(5, 5, 7, 6);
    push(9, 1, 9, 4);
    push(2, 8, 0, 6);
    push(4, 4, 1, 5);
    check("full_ready", {31'd0, cmd_ready_o}, 0);
    check("full_busy", {31'd0, busy_o}, 1);
    push(6, 0, 10, 0);
    push(3, 3, 3, 3);
    cmd_valid_i = 1'b0;
    wait_idle();
    end_of_test("fifo_full");

    // stuck drawer: abort on timeout, then recover
    stub_mode = 1;
    push(0, 0, 5, 0);
    cmd_valid_i = 1'b0;
    wait_idle();
    check("to_err", {31'd0, timeout_err_o}, 1);
    end_of_test("timeout");
    stub_mode = 0;
    push(2, 2, 4, 3);
    cmd_valid_i = 1'b0;
    wait_idle();
    end_of_test("after_timeout");
    check("to_sticky", {31'd0, timeout_err_o}, 1);

    // randomized commands and gaps
    for (int i = 0; i < 20; i++) begin
      rx0 = $urandom_range(0, 12); ry0 = $urandom_range(0, 12);
      rx1 = $urandom_range(0, 12); ry1 = $urandom_range(0, 12);
      push(rx0 + 50, ry0 + 20, rx1 + 50, ry1 + 20);
      cmd_valid_i = 1'b0;
      tick($urandom_range(0, 15));
    end
    wait_idle();
    end_of_test("random");

    // reset mid-line with commands queued
    push(0, 0, 11, 4);
    push(1, 1, 2, 2);
    push(3, 3, 4, 4);
    cmd_valid_i = 1'b0;
    ok = 0;
    for (int t = 0; t < 50; t++) begin
      if (dk == 4 && !drw_reset_o) begin ok = 1; break; end
      tick(1);
    end
    check("rst_mid_reach", {31'd0, ok}, 1);
    reset = 1'b1;
    tick(1);
    exp_q.delete();
    exp_lines = 0;
    check("mid_rst_we", {31'd0, pix_we_o}, 0);
    check("mid_rst_drw_reset", {31'd0, drw_reset_o}, 1);
    check("mid_rst_ready", {31'd0, cmd_ready_o}, 0);
    reset = 1'b0;
    wr_count = 0;
    tick(40);
    check("post_rst_writes", wr_count, 0);
    check("post_rst_busy", {31'd0, busy_o}, 0);
    check("post_rst_lines", {16'd0, lines_done_o}, 0);
    check("post_rst_timeout", {31'd0, timeout_err_o}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
